pixel_serializer: RTL and testbench
===================================

Name: pixel_serializer

Overview:
Parametrised successor to the fixed 16-bit dot shifter. Converts a stream of fetched display words into one colour index per dot clock. Supports 1/2/4/8 bpp modes and horizontal pixel repetition. A one-word holding buffer with a valid/ready handshake lets the fetch engine stay one word ahead, so there are no bubbles at word boundaries. Sits between the video fetch unit and the palette lookup.

Parameters:
DATA_W, 16, fetched word width; a multiple of 8 and at least 8.
COLOR_W, 8, colour index width; at least 8; narrower pixels are zero-extended.
HREP_W, 2, width of the horizontal repeat field.

Ports:
dotclk_i  in  1  dot clock; all state changes on its rising edge.
reset_i  in  1  asynchronous, active-high reset.
mode_i  in  2  pixel depth: 0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp.
hrep_i  in  HREP_W  each pixel is shown for hrep_i+1 dots.
en_i  in  1  active display; pixels advance only when high.
flush_i  in  1  synchronous discard of all buffered data (end of line).
dat_i  in  DATA_W  fetched word; MSB-first pixel order.
dat_valid_i  in  1  dat_i is valid.
dat_ready_o  out  1  block accepts dat_i this cycle.
color_o  out  COLOR_W  registered colour index.
color_valid_o  out  1  color_o holds a real pixel.
underrun_o  out  1  one-cycle pulse: en_i high with no pixel available.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears sr, hold, pix_cnt, rep_cnt, hold_full, mode_q, hrep_q.
  - color_o=0, color_valid_o=0, underrun_o=0.
  - dat_ready_o=0 while reset_i is high.
- Derived quantities: bpp = 1<<mode. Pixels per word ppw = DATA_W>>mode; for DATA_W=16: 16/8/4/2.
- Handshake:
  - dat_ready_o = ~hold_full & ~flush_i & ~reset_i.
  - A word is accepted when dat_valid_i & dat_ready_o.
- Word placement on accept:
  - If sr will be empty after this edge, the word loads directly into sr (bypass).
  - Otherwise it goes to hold and hold_full is set.
- Loading sr:
  - Latches mode_i into mode_q and hrep_i into hrep_q.
  - Sets pix_cnt=ppw(mode_i) and rep_cnt=0.
  - mode_i and hrep_i are sampled only at sr load; changes mid-word have no effect.
- Refill: whenever sr is empty (pix_cnt==0) or its last dot completes this edge, and hold_full=1:
  - sr loads from hold and hold_full clears.
  - This happens regardless of en_i.
  - If a new word is accepted on the same edge, it enters hold and hold_full stays 1.
- Each edge with en_i=1 and pix_cnt>0:
  - color_o <= zero-extended sr[DATA_W-1 -: bpp] (mode_q); color_valid_o <= 1.
  - If rep_cnt==hrep_q: rep_cnt <= 0, sr shifts left by bpp, pix_cnt decrements.
  - Else rep_cnt increments.
- Edge with en_i=1 and pix_cnt==0:
  - color_o <= 0, color_valid_o <= 0, underrun_o <= 1.
- Edge with en_i=0:
  - color_o <= 0, color_valid_o <= 0, underrun_o <= 0.
  - sr, counters and hold are frozen; refill/bypass loads still occur.
- flush_i=1:
  - Next edge clears sr, pix_cnt, rep_cnt and hold_full.
  - color_o/color_valid_o take their en_i=0 values; no word is accepted.
  - flush_i has priority over every other event.
- Latency:
  - Word accepted in cycle N with sr empty: first pixel appears on color_o in cycle N+2 (registered after edge N+1).
  - Back-to-back words with hold_full=1 give gapless output.
- Boundary: last dot of a word with hold empty and a simultaneous accept → bypass into sr, no bubble.

Decomposition:
- Package cgia_pkg holds:
  - MODE_1BPP..MODE_8BPP constants.
  - A ppw(mode, DATA_W) function.
  - A bpp(mode) function.
- Sub-module pixel_select: combinational, picks and zero-extends the top bpp bits of sr for a given mode; reusable by the sprite path.

Test Plan:
1. 1bpp, hrep=0, dat_i=16'hA5C3 accepted with sr empty, en_i held high → from N+2, color_o = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; color_valid_o=1 for 16 cycles.
2. 2bpp then 4bpp, words 16'hA5C3 then 16'hA5C3, valid held high → color_o = 2,2,1,1,3,0,0,3 then A,5,C,3; mode switches exactly at the word boundary; no gap.
3. 8bpp, hrep=1, 16'hA5C3 → color_o = A5,A5,C3,C3; then with no further word, underrun_o=1 and color_valid_o=0 on the next edge.
4. Fill sr and hold, keep dat_valid_i high → dat_ready_o=0 until sr's last dot completes, then 1 for one cycle as hold drains; no word lost or duplicated.
5. Assert flush_i mid-word with dat_valid_i high → dat_ready_o=0 that cycle; next cycle pix_cnt=0 and hold_full=0; with en_i high, underrun_o=1.
6. Assert reset_i asynchronously mid-word → color_o, color_valid_o and underrun_o drop to 0 immediately; after release, dat_ready_o=1 and the first accepted word displays from its MSB pixel.

Source files
------------

// File: rtl/pixel_serializer_pkg.sv
// Shared pixel-depth definitions for the display pipeline (dot shifter, sprite path).
package cgia_pkg;

  typedef enum logic [1:0] {
    MODE_1BPP = 2'd0,
    MODE_2BPP = 2'd1,
    MODE_4BPP = 2'd2,
    MODE_8BPP = 2'd3
  } mode_e;

  function automatic int unsigned bpp(input logic [1:0] mode);
    return 32'd1 << mode;
  endfunction

  function automatic int unsigned ppw(input logic [1:0] mode, input int unsigned data_w);
    return data_w >> mode;
  endfunction

endpackage

// File: rtl/pixel_serializer_pixel_select.sv
// Picks the top bpp bits of a shift register and zero-extends them to a colour index.
module pixel_select
  import cgia_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COLOR_W = 8
) (
  input  logic [DATA_W-1:0]  i_sr,
  input  mode_e              i_mode,
  output logic [COLOR_W-1:0] o_pix
);

  always_comb begin
    o_pix = '0;
    unique case (i_mode)
      MODE_1BPP: o_pix[0:0] = i_sr[DATA_W-1 -: 1];
      MODE_2BPP: o_pix[1:0] = i_sr[DATA_W-1 -: 2];
      MODE_4BPP: o_pix[3:0] = i_sr[DATA_W-1 -: 4];
      MODE_8BPP: o_pix[7:0] = i_sr[DATA_W-1 -: 8];
    endcase
  end

endmodule

// File: rtl/pixel_serializer.sv
// Display word to colour-index serializer with a one-word holding buffer so the
// fetch engine can stay a word ahead; supports 1/2/4/8 bpp and horizontal repeat.
module pixel_serializer
  import cgia_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned HREP_W  = 2
) (
  input  logic               dotclk_i,
  input  logic               reset_i,
  input  logic [1:0]         mode_i,
  input  logic [HREP_W-1:0]  hrep_i,
  input  logic               en_i,
  input  logic               flush_i,
  input  logic [DATA_W-1:0]  dat_i,
  input  logic               dat_valid_i,
  output logic               dat_ready_o,
  output logic [COLOR_W-1:0] color_o,
  output logic               color_valid_o,
  output logic               underrun_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]  r_sr,       w_sr_nxt;
  logic [DATA_W-1:0]  r_hold,     w_hold_nxt;
  logic [CNT_W-1:0]   r_pix_cnt,  w_pix_nxt;
  logic [HREP_W-1:0]  r_rep_cnt,  w_rep_nxt;
  logic               r_hold_full, w_hf_nxt;
  mode_e              r_mode_q,   w_mode_nxt;
  logic [HREP_W-1:0]  r_hrep_q,   w_hrep_nxt;
  logic [COLOR_W-1:0] r_color,    w_color_nxt;
  logic               r_cvalid,   w_cvalid_nxt;
  logic               r_under,    w_under_nxt;

  logic               w_accept;
  logic               w_last_dot;
  logic               w_sr_empty_nxt;
  logic               w_load;
  logic [DATA_W-1:0]  w_load_word;
  logic [COLOR_W-1:0] w_pix;

  pixel_select #(
    .DATA_W  (DATA_W),
    .COLOR_W (COLOR_W)
  ) u_pixel_select (
    .i_sr   (r_sr),
    .i_mode (r_mode_q),
    .o_pix  (w_pix)
  );

  assign dat_ready_o    = ~r_hold_full & ~flush_i & ~reset_i;
  assign w_accept       = dat_valid_i & dat_ready_o;
  assign w_last_dot     = en_i && (r_pix_cnt == CNT_W'(1)) && (r_rep_cnt == r_hrep_q);
  assign w_sr_empty_nxt = (r_pix_cnt == '0) || w_last_dot;
  // Hold always drains first; a fresh word bypasses only when hold is empty.
  assign w_load         = w_sr_empty_nxt && (r_hold_full || w_accept);
  assign w_load_word    = r_hold_full ? r_hold : dat_i;

  always_comb begin
    w_sr_nxt     = r_sr;
    w_hold_nxt   = r_hold;
    w_pix_nxt    = r_pix_cnt;
    w_rep_nxt    = r_rep_cnt;
    w_hf_nxt     = r_hold_full;
    w_mode_nxt   = r_mode_q;
    w_hrep_nxt   = r_hrep_q;
    w_color_nxt  = '0;
    w_cvalid_nxt = 1'b0;
    w_under_nxt  = 1'b0;

    if (flush_i) begin
      w_sr_nxt  = '0;
      w_pix_nxt = '0;
      w_rep_nxt = '0;
      w_hf_nxt  = 1'b0;
    end else begin
      if (en_i) begin
        if (r_pix_cnt != '0) begin
          w_color_nxt  = w_pix;
          w_cvalid_nxt = 1'b1;
          if (r_rep_cnt == r_hrep_q) begin
            w_rep_nxt = '0;
            w_sr_nxt  = r_sr << bpp(r_mode_q);
            w_pix_nxt = r_pix_cnt - CNT_W'(1);
          end else begin
            w_rep_nxt = r_rep_cnt + HREP_W'(1);
          end
        end else begin
          w_under_nxt = 1'b1;
        end
      end

      if (w_load) begin
        w_sr_nxt   = w_load_word;
        w_mode_nxt = mode_e'(mode_i);
        w_hrep_nxt = hrep_i;
        w_pix_nxt  = CNT_W'(ppw(mode_i, DATA_W));
        w_rep_nxt  = '0;
        w_hf_nxt   = 1'b0;
      end

      if (w_accept && !w_sr_empty_nxt) begin
        w_hold_nxt = dat_i;
        w_hf_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge dotclk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sr        <= '0;
      r_hold      <= '0;
      r_pix_cnt   <= '0;
      r_rep_cnt   <= '0;
      r_hold_full <= 1'b0;
      r_mode_q    <= MODE_1BPP;
      r_hrep_q    <= '0;
      r_color     <= '0;
      r_cvalid    <= 1'b0;
      r_under     <= 1'b0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_hold      <= w_hold_nxt;
      r_pix_cnt   <= w_pix_nxt;
      r_rep_cnt   <= w_rep_nxt;
      r_hold_full <= w_hf_nxt;
      r_mode_q    <= w_mode_nxt;
      r_hrep_q    <= w_hrep_nxt;
      r_color     <= w_color_nxt;
      r_cvalid    <= w_cvalid_nxt;
      r_under     <= w_under_nxt;
    end
  end

  assign color_o       = r_color;
  assign color_valid_o = r_cvalid;
  assign underrun_o    = r_under;

endmodule

// File: tb/tb_pixel_serializer.sv
// Scoreboard bench for pixel_serializer: expected dots are queued on word accept.
module tb_pixel_serializer;

  logic        dotclk_i;
  logic        reset_i;
  logic [1:0]  mode_i;
  logic [1:0]  hrep_i;
  logic        en_i;
  logic        flush_i;
  logic [15:0] dat_i;
  logic        dat_valid_i;
  logic        dat_ready_o;
  logic [7:0]  color_o;
  logic        color_valid_o;
  logic        underrun_o;

  int unsigned n_pass;
  int unsigned n_total;
  int unsigned nvalid;
  logic        last_ready;
  logic [7:0]  exp_q[$];

  pixel_serializer #(
    .DATA_W  (16),
    .COLOR_W (8),
    .HREP_W  (2)
  ) dut (
    .dotclk_i      (dotclk_i),
    .reset_i       (reset_i),
    .mode_i        (mode_i),
    .hrep_i        (hrep_i),
    .en_i          (en_i),
    .flush_i       (flush_i),
    .dat_i         (dat_i),
    .dat_valid_i   (dat_valid_i),
    .dat_ready_o   (dat_ready_o),
    .color_o       (color_o),
    .color_valid_o (color_valid_o),
    .underrun_o    (underrun_o)
  );

  initial begin
    dotclk_i = 1'b0;
    forever #5 dotclk_i = ~dotclk_i;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic push_word(input logic [15:0] w, input logic [1:0] m, input logic [1:0] h);
    int unsigned b;
    int unsigned n;
    logic [15:0] t;
    logic [15:0] msk;
    b   = 32'd1 << m;
    n   = 32'd16 >> m;
    msk = (16'd1 << b) - 16'd1;
    for (int unsigned i = 0; i < n; i++) begin
      t = (w >> (16 - b * (i + 1))) & msk;
      for (int unsigned r = 0; r <= 32'(h); r++) exp_q.push_back(t[7:0]);
    end
  endtask

  // One dot clock: decide acceptance before the edge, check the output after it.
  task automatic tick();
    logic acc;
    #1;
    last_ready = dat_ready_o;
    acc = dat_valid_i && dat_ready_o;
    if (acc) push_word(dat_i, mode_i, hrep_i);
    @(posedge dotclk_i);
    #1;
    if (color_valid_o) begin
      nvalid++;
      if (exp_q.size() == 0) check("spurious_valid", 32'(color_valid_o), 32'd0);
      else check("pixel", 32'(color_o), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic drain_and_check_end();
    int unsigned budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      tick();
      budget++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    tick();
    check("end_valid", 32'(color_valid_o), 32'd0);
    check("end_underrun", 32'(underrun_o), 32'(en_i));
  endtask

  task automatic send(input logic [15:0] w);
    dat_i       = w;
    dat_valid_i = 1'b1;
    tick();
    dat_valid_i = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; nvalid = 0;
    reset_i = 1'b1; mode_i = 2'd0; hrep_i = 2'd0; en_i = 1'b0;
    flush_i = 1'b0; dat_i = '0; dat_valid_i = 1'b0;

    #1;
    check("rst_color", 32'(color_o), 32'd0);
    check("rst_valid", 32'(color_valid_o), 32'd0);
    check("rst_underrun", 32'(underrun_o), 32'd0);
    check("rst_ready", 32'(dat_ready_o), 32'd0);
    @(posedge dotclk_i);
    #1;
    reset_i = 1'b0;
    #1;
    check("ready_after_rst", 32'(dat_ready_o), 32'd1);

    // 1bpp, no repeat, latency and dot count
    en_i = 1'b1;
    send(16'hA5C3);
    check("t1_lat_n1", 32'(color_valid_o), 32'd0);
    nvalid = 0;
    tick();
    check("t1_lat_n2", 32'(color_valid_o), 32'd1);
    repeat (15) tick();
    check("t1_count", nvalid, 32'd16);
    drain_and_check_end();

    // 2bpp word then 4bpp word, gapless across the boundary
    mode_i = 2'd1;
    send(16'hA5C3);
    mode_i = 2'd2;
    send(16'hA5C3);
    for (int i = 0; i < 11; i++) begin
      tick();
      check("t2_gapless", 32'(color_valid_o), 32'd1);
    end
    drain_and_check_end();

    // 8bpp, each pixel doubled, then underrun
    mode_i = 2'd3; hrep_i = 2'd1;
    send(16'hA5C3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_valid", 32'(color_valid_o), 32'd1);
    end
    drain_and_check_end();
    en_i = 1'b0;
    tick();
    check("t3_idle_underrun", 32'(underrun_o), 32'd0);
    hrep_i = 2'd0;

    // fill sr and hold, then watch ready while the first word drains
    mode_i = 2'd0;
    send(16'h1234);
    send(16'h5678);
    dat_i = 16'h9ABC; dat_valid_i = 1'b1;
    #1;
    check("t4_ready_full", 32'(dat_ready_o), 32'd0);
    en_i = 1'b1;
    begin
      int unsigned first_rdy;
      first_rdy = 0;
      for (int unsigned k = 1; k <= 40 && first_rdy == 0; k++) begin
        tick();
        if (last_ready) first_rdy = k;
      end
      dat_valid_i = 1'b0;
      check("t4_ready_rise", first_rdy, 32'd17);
    end
    tick();
    check("t4_ready_one_cycle", 32'(last_ready), 32'd0);
    drain_and_check_end();

    // flush mid-word with a word pending in hold
    send(16'hF00F);
    send(16'h0FF0);
    repeat (3) tick();
    flush_i = 1'b1; dat_i = 16'h1111; dat_valid_i = 1'b1;
    #1;
    check("t5_flush_ready", 32'(dat_ready_o), 32'd0);
    exp_q.delete();
    tick();
    check("t5_flush_valid", 32'(color_valid_o), 32'd0);
    check("t5_flush_underrun", 32'(underrun_o), 32'd0);
    flush_i = 1'b0; dat_valid_i = 1'b0;
    tick();
    check("t5_post_underrun", 32'(underrun_o), 32'd1);
    tick();
    check("t5_hold_cleared", 32'(color_valid_o), 32'd0);

    // asynchronous reset mid-word
    mode_i = 2'd3;
    send(16'hA5C3);
    tick();
    check("t6_pre_valid", 32'(color_valid_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    check("t6_rst_color", 32'(color_o), 32'd0);
    check("t6_rst_valid", 32'(color_valid_o), 32'd0);
    check("t6_rst_underrun", 32'(underrun_o), 32'd0);
    check("t6_rst_ready", 32'(dat_ready_o), 32'd0);
    exp_q.delete();
    @(posedge dotclk_i);
    #1;
    reset_i = 1'b0;
    #1;
    check("t6_ready_after", 32'(dat_ready_o), 32'd1);
    mode_i = 2'd0;
    send(16'h8001);
    tick();
    check("t6_first_dot_valid", 32'(color_valid_o), 32'd1);
    drain_and_check_end();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
